// File: rtl/wb_down_seq.sv
// Wide-to-narrow Wishbone sequencer: splits one wide access into one narrow beat per
// active 32-bit lane (lowest first), gathers read data, and returns a single ack or err.
module wb_down_seq #(
    parameter int AW      = 32,
    parameter int SDW     = 128,
    parameter int MDW     = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [AW-1:0]     i_s_wb_adr,
    input  logic [SDW/8-1:0]  i_s_wb_sel,
    input  logic              i_s_wb_we,
    input  logic [SDW-1:0]    i_s_wb_dat,
    output logic [SDW-1:0]    o_s_wb_dat,
    input  logic              i_s_wb_cyc,
    input  logic              i_s_wb_stb,
    output logic              o_s_wb_ack,
    output logic              o_s_wb_err,
    output logic [AW-1:0]     o_m_wb_adr,
    output logic [MDW/8-1:0]  o_m_wb_sel,
    output logic              o_m_wb_we,
    output logic [MDW-1:0]    o_m_wb_dat,
    input  logic [MDW-1:0]    i_m_wb_dat,
    output logic              o_m_wb_cyc,
    output logic              o_m_wb_stb,
    input  logic              i_m_wb_ack,
    input  logic              i_m_wb_err,
    output logic [1:0]        o_dbg_state
);
    localparam int SSW  = SDW / 8;
    localparam int MSW  = MDW / 8;
    localparam int NL   = SDW / MDW;
    localparam int LSDW = $clog2(SDW / 8);
    localparam int LMDW = $clog2(MDW / 8);
    localparam int LW   = LSDW - LMDW;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT  = 2'd1,
        S_RESP  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:LSDW]  adr_q, adr_d;
    logic              we_q, we_d;
    logic [SDW-1:0]    wdat_q, wdat_d;
    logic [SSW-1:0]    sel_q, sel_d;
    logic [NL-1:0]     mask_q, mask_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [SDW-1:0]    rbuf_q, rbuf_d;
    logic              err_q, err_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;

    logic [SDW-1:0]    s_dat_q, s_dat_d;
    logic              s_ack_q, s_ack_d;
    logic              s_err_q, s_err_d;
    logic [AW-1:0]     m_adr_q, m_adr_d;
    logic [MSW-1:0]    m_sel_q, m_sel_d;
    logic              m_we_q, m_we_d;
    logic [MDW-1:0]    m_dat_q, m_dat_d;
    logic              m_cyc_q, m_cyc_d;

    logic [NL-1:0]     req_mask;
    logic              timeout;
    logic              unused_adr_lo;

    assign unused_adr_lo = ^i_s_wb_adr[LSDW-1:0];

    function automatic logic [LW-1:0] lowest_lane(input logic [NL-1:0] m);
        lowest_lane = '0;
        for (int k = NL - 1; k >= 0; k--) begin
            if (m[k]) lowest_lane = LW'(k);
        end
    endfunction

    always_comb begin
        req_mask = '0;
        for (int k = 0; k < NL; k++) begin
            req_mask[k] = |i_s_wb_sel[k*MSW +: MSW];
        end
    end

    // Fires on the TIMEOUT-th cycle of a beat that sees neither ack nor err.
    assign timeout = (TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        mask_d  = mask_q;
        lane_d  = lane_q;
        rbuf_d  = rbuf_q;
        err_d   = err_q;
        tcnt_d  = tcnt_q;
        s_dat_d = s_dat_q;
        s_ack_d = 1'b0;
        s_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_s_wb_cyc && i_s_wb_stb) begin
                    adr_d   = i_s_wb_adr[AW-1:LSDW];
                    we_d    = i_s_wb_we;
                    wdat_d  = i_s_wb_dat;
                    sel_d   = i_s_wb_sel;
                    mask_d  = req_mask;
                    lane_d  = lowest_lane(req_mask);
                    rbuf_d  = '0;
                    err_d   = 1'b0;
                    tcnt_d  = '0;
                    s_dat_d = '0;
                    state_d = (req_mask == '0) ? S_RESP : S_BEAT;
                end
            end
            S_BEAT: begin
                if (!i_s_wb_cyc) begin
                    state_d = S_ABORT;
                end else if (i_m_wb_err) begin
                    err_d   = 1'b1;
                    mask_d  = '0;
                    state_d = S_RESP;
                end else if (i_m_wb_ack) begin
                    if (!we_q) rbuf_d[lane_q*MDW +: MDW] = i_m_wb_dat;
                    mask_d = mask_q & ~(NL'(1) << lane_q);
                    tcnt_d = '0;
                    if (mask_d == '0) state_d = S_RESP;
                    else              lane_d  = lowest_lane(mask_d);
                end else if (timeout) begin
                    err_d   = 1'b1;
                    mask_d  = '0;
                    state_d = S_RESP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the next-state values.
        if (state_d == S_RESP) begin
            s_ack_d = !err_d;
            s_err_d = err_d;
            s_dat_d = we_d ? '0 : rbuf_d;
        end

        m_cyc_d = (state_d == S_BEAT);
        m_adr_d = '0;
        m_sel_d = '0;
        m_we_d  = 1'b0;
        m_dat_d = '0;
        if (state_d == S_BEAT) begin
            m_adr_d = {adr_d, lane_d, {LMDW{1'b0}}};
            m_sel_d = sel_d[lane_d*MSW +: MSW];
            m_we_d  = we_d;
            m_dat_d = wdat_d[lane_d*MDW +: MDW];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            sel_q   <= '0;
            mask_q  <= '0;
            lane_q  <= '0;
            rbuf_q  <= '0;
            err_q   <= 1'b0;
            tcnt_q  <= '0;
            s_dat_q <= '0;
            s_ack_q <= 1'b0;
            s_err_q <= 1'b0;
            m_adr_q <= '0;
            m_sel_q <= '0;
            m_we_q  <= 1'b0;
            m_dat_q <= '0;
            m_cyc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            mask_q  <= mask_d;
            lane_q  <= lane_d;
            rbuf_q  <= rbuf_d;
            err_q   <= err_d;
            tcnt_q  <= tcnt_d;
            s_dat_q <= s_dat_d;
            s_ack_q <= s_ack_d;
            s_err_q <= s_err_d;
            m_adr_q <= m_adr_d;
            m_sel_q <= m_sel_d;
            m_we_q  <= m_we_d;
            m_dat_q <= m_dat_d;
            m_cyc_q <= m_cyc_d;
        end
    end

    assign o_s_wb_dat  = s_dat_q;
    assign o_s_wb_ack  = s_ack_q;
    assign o_s_wb_err  = s_err_q;
    assign o_m_wb_adr  = m_adr_q;
    assign o_m_wb_sel  = m_sel_q;
    assign o_m_wb_we   = m_we_q;
    assign o_m_wb_dat  = m_dat_q;
    assign o_m_wb_cyc  = m_cyc_q;
    assign o_m_wb_stb  = m_cyc_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_wb_down_seq.sv
// Randomized bench for wb_down_seq: a lane-level model predicts every narrow beat,
// the wide response cycle, status and gathered read data.
module tb_wb_down_seq;
  localparam int AW  = 32;
  localparam int SDW = 128;
  localparam int MDW = 32;
  localparam int TMO = 4;
  localparam int NL  = SDW / MDW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [AW-1:0]     s_adr = '0;
  logic [SDW/8-1:0]  s_sel = '0;
  logic              s_we = 1'b0;
  logic [SDW-1:0]    s_wdat = '0;
  logic [SDW-1:0]    o_s_wb_dat;
  logic              s_cyc = 1'b0;
  logic              s_stb = 1'b0;
  logic              o_s_wb_ack, o_s_wb_err;
  logic [AW-1:0]     o_m_wb_adr;
  logic [MDW/8-1:0]  o_m_wb_sel;
  logic              o_m_wb_we;
  logic [MDW-1:0]    o_m_wb_dat;
  logic [MDW-1:0]    m_rdat = '0;
  logic              o_m_wb_cyc, o_m_wb_stb;
  logic              m_ack = 1'b0;
  logic              m_err = 1'b0;
  logic [1:0]        o_dbg_state;

  always #5 clk = ~clk;

  wb_down_seq #(.AW(AW), .SDW(SDW), .MDW(MDW), .TIMEOUT(TMO)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_s_wb_adr (s_adr),
    .i_s_wb_sel (s_sel),
    .i_s_wb_we  (s_we),
    .i_s_wb_dat (s_wdat),
    .o_s_wb_dat (o_s_wb_dat),
    .i_s_wb_cyc (s_cyc),
    .i_s_wb_stb (s_stb),
    .o_s_wb_ack (o_s_wb_ack),
    .o_s_wb_err (o_s_wb_err),
    .o_m_wb_adr (o_m_wb_adr),
    .o_m_wb_sel (o_m_wb_sel),
    .o_m_wb_we  (o_m_wb_we),
    .o_m_wb_dat (o_m_wb_dat),
    .i_m_wb_dat (m_rdat),
    .o_m_wb_cyc (o_m_wb_cyc),
    .o_m_wb_stb (o_m_wb_stb),
    .i_m_wb_ack (m_ack),
    .i_m_wb_err (m_err),
    .o_dbg_state(o_dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // per-lane behaviour of the narrow slave for the next transaction
  int          waits[NL];
  bit          errs[NL];
  bit          both[NL];
  logic [31:0] rdata[NL];

  logic [68:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_lanes(input int w, input bit e);
    for (int k = 0; k < NL; k++) begin
      waits[k] = w;
      errs[k]  = e;
      both[k]  = 1'b0;
      rdata[k] = $urandom;
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({o_s_wb_dat != '0, o_s_wb_ack, o_s_wb_err, o_m_wb_adr, o_m_wb_sel,
                 o_m_wb_we, o_m_wb_dat, o_m_wb_cyc, o_m_wb_stb, o_dbg_state});
  endfunction

  // slave response for the current narrow cycle; wcnt counts wait cycles of this beat
  task automatic slave_step(inout int wcnt);
    int lane;
    m_ack  = 1'b0;
    m_err  = 1'b0;
    m_rdat = $urandom;
    if (o_m_wb_stb) begin
      lane = int'(o_m_wb_adr[3:2]);
      if (wcnt >= waits[lane]) begin
        if (errs[lane]) begin
          m_err = 1'b1;
          m_ack = both[lane];
        end else begin
          m_ack = 1'b1;
        end
        m_rdat = rdata[lane];
        wcnt   = 0;
      end else begin
        wcnt++;
      end
    end
  endtask

  task automatic run_txn(input logic [31:0] adr, input logic [15:0] sel,
                         input logic we, input logic [127:0] wdat);
    int          total;
    int          span;
    int          wcnt;
    logic [127:0] exp_rd;
    logic        exp_err;
    logic [3:0]  nib;
    logic [31:0] ba;
    exp_q   = {};
    total   = 0;
    exp_rd  = '0;
    exp_err = 1'b0;
    for (int k = 0; k < NL; k++) begin
      nib = sel[k*4 +: 4];
      if (nib != 4'h0 && !exp_err) begin
        if (waits[k] >= TMO) begin
          span    = TMO;
          exp_err = 1'b1;
        end else begin
          span = waits[k] + 1;
          if (errs[k]) exp_err = 1'b1;
          else if (!we) exp_rd[k*32 +: 32] = rdata[k];
        end
        ba = {adr[31:4], 4'h0} + 32'(k * 4);
        for (int j = 0; j < span; j++) exp_q.push_back({ba, nib, we, wdat[k*32 +: 32]});
        total += span;
      end
    end

    @(negedge clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_adr = adr; s_sel = sel; s_we = we; s_wdat = wdat;
    wcnt = 0;
    for (int c = 1; c <= total + 2; c++) begin
      @(negedge clk);
      check("m_stb", 128'(o_m_wb_stb), 128'(c <= total));
      check("m_cyc", 128'(o_m_wb_cyc), 128'(c <= total));
      check("s_ack", 128'(o_s_wb_ack), 128'(c == total + 1 && !exp_err));
      check("s_err", 128'(o_s_wb_err), 128'(c == total + 1 && exp_err));
      if (c <= total && exp_q.size() > 0)
        check("beat", 128'({o_m_wb_adr, o_m_wb_sel, o_m_wb_we, o_m_wb_dat}), 128'(exp_q.pop_front()));
      slave_step(wcnt);
      if (c == total + 1) begin
        check("s_dat", o_s_wb_dat, exp_rd);
        s_cyc = 1'b0; s_stb = 1'b0;
      end
    end
    m_ack = 1'b0; m_err = 1'b0;
    check("beats_left", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic start_req(input logic [31:0] adr, input logic [15:0] sel);
    @(negedge clk);
    s_cyc = 1'b1; s_stb = 1'b1; s_adr = adr; s_sel = sel; s_we = 1'b0; s_wdat = '0;
  endtask

  initial begin
    int wc;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // full read, zero wait
    set_lanes(0, 1'b0);
    rdata[0] = 32'h11111111; rdata[1] = 32'h22222222;
    rdata[2] = 32'h33333333; rdata[3] = 32'h44444444;
    run_txn(32'h100, 16'hFFFF, 1'b0, '0);

    // sparse writes
    set_lanes(0, 1'b0);
    run_txn(32'h20, 16'h00FC, 1'b1, {4{32'hAAAAAAAA}});
    run_txn(32'h20, 16'h0F0C, 1'b1, {4{32'hAAAAAAAA}});

    // zero-lane access, read then write
    run_txn(32'h40, 16'h0000, 1'b0, '0);
    run_txn(32'h40, 16'h0000, 1'b1, {4{32'h55555555}});

    // error on lane 1, and ack+err together on lane 2
    set_lanes(0, 1'b0);
    errs[1] = 1'b1;
    run_txn(32'h200, 16'hFFFF, 1'b0, '0);
    set_lanes(1, 1'b0);
    errs[2] = 1'b1; both[2] = 1'b1;
    run_txn(32'h300, 16'hFFFF, 1'b0, '0);

    // timeout on first lane, then on a late lane after wait states
    set_lanes(50, 1'b0);
    run_txn(32'h400, 16'hFFFF, 1'b0, '0);
    set_lanes(TMO - 1, 1'b0);
    waits[3] = 50;
    run_txn(32'h500, 16'hF0F0, 1'b1, {$urandom, $urandom, $urandom, $urandom});

    // wide master drops cyc during beat 2
    set_lanes(0, 1'b0);
    waits[1] = 50;
    start_req(32'h600, 16'hFFFF);
    wc = 0;
    @(negedge clk);
    check("abort_b1", 128'({o_m_wb_stb, o_m_wb_adr}), 128'({1'b1, 32'h600}));
    slave_step(wc);
    @(negedge clk);
    check("abort_b2", 128'({o_m_wb_stb, o_m_wb_adr}), 128'({1'b1, 32'h604}));
    m_ack = 1'b0; m_err = 1'b0;
    s_cyc = 1'b0; s_stb = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_quiet", 128'({o_m_wb_cyc, o_m_wb_stb, o_s_wb_ack, o_s_wb_err}), 128'(0));
    end

    // reset pulse mid-beat
    set_lanes(50, 1'b0);
    start_req(32'h700, 16'hFFFF);
    @(negedge clk);
    @(negedge clk);
    check("rst_pre", 128'(o_m_wb_stb), 128'(1));
    rst_n = 1'b0;
    #1;
    check("rst_async", all_outs(), 128'(0));
    s_cyc = 1'b0; s_stb = 1'b0;
    #1 rst_n = 1'b1;
    set_lanes(0, 1'b0);
    run_txn(32'h800, 16'hFFFF, 1'b0, '0);

    // random traffic
    for (int t = 0; t < 60; t++) begin
      logic [15:0] sel;
      for (int k = 0; k < NL; k++) begin
        waits[k] = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, TMO - 1));
        errs[k]  = ($urandom_range(0, 9) == 0);
        both[k]  = $urandom_range(0, 1);
        rdata[k] = $urandom;
      end
      case ($urandom_range(0, 5))
        0:       sel = 16'h0000;
        1:       sel = 16'hFFFF;
        default: sel = 16'($urandom);
      endcase
      run_txn($urandom, sel, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
